// File: rtl/spike_frame_serializer_pkg.sv
// Shared definitions for the spike frame serializer: default sync byte,
// frame length and the byte-position state encoding.
package spike_frame_serializer_pkg;

  localparam logic [7:0]  SYNC_BYTE_DEFAULT = 8'hA5;
  localparam int unsigned FRAME_LEN         = 7;

  // One state per transmitted byte, plus IDLE.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_SEQ,
    ST_D3,
    ST_D2,
    ST_D1,
    ST_D0,
    ST_CHK
  } frame_state_t;

endpackage

// File: rtl/spike_word_fifo.sv
// Synchronous word FIFO.
//   clk, rst_n   : clock, asynchronous active-low reset
//   push, wdata  : write request (ignored when full)
//   pop, rdata   : read request (ignored when empty); rdata shows the head word
//   full, empty  : status flags
//   level        : number of words held (0..DEPTH)
module spike_word_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Pointers carry one extra MSB so full and empty are distinguishable.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level   = wr_ptr - rd_ptr;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/spike_frame_serializer.sv
// Buffers 32-bit merged spike words and serializes each into a 7-byte frame
// {SYNC, seq, d[31:24], d[23:16], d[15:8], d[7:0], xor checksum} on an 8-bit
// AXI-Stream toward the UART. Sends heartbeat frames after idle periods.
//   aclk, aresetn        : clock, asynchronous active-low reset
//   s_axis_*             : 32-bit word input (tready = FIFO not full)
//   m_axis_*             : 8-bit byte output
//   seq_num              : sequence number of the current / last frame
//   fifo_level           : words held in the input FIFO
module spike_frame_serializer
  import spike_frame_serializer_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH       = 4,
  parameter logic [7:0]  SYNC_BYTE        = SYNC_BYTE_DEFAULT,
  parameter int unsigned HEARTBEAT_CYCLES = 12000000,
  parameter logic [31:0] HEARTBEAT_WORD   = 32'hFFFF_FFFF
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic [31:0]                   s_axis_tdata,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  output logic [7:0]                    m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic [7:0]                    seq_num,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  frame_state_t state;
  frame_state_t state_next;
  logic [31:0]  hold;
  logic [7:0]   chk;
  logic [7:0]   seq;
  logic [31:0]  idle_cnt;
  logic         out_of_reset;
  logic         fifo_full;
  logic         fifo_empty;
  logic [31:0]  fifo_rdata;
  logic         push;
  logic         pop;
  logic         hb_load;
  logic         hb_fire;
  logic         out_hs;

  spike_word_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk   (aclk),
    .rst_n (aresetn),
    .push  (push),
    .wdata (s_axis_tdata),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // tready is held low until the first clock after reset release.
  assign s_axis_tready = out_of_reset && !fifo_full;
  assign push          = s_axis_tvalid && s_axis_tready;
  assign m_axis_tvalid = (state != ST_IDLE);
  assign out_hs        = m_axis_tvalid && m_axis_tready;
  assign seq_num       = seq;
  assign hb_fire       = (HEARTBEAT_CYCLES != 0) &&
                         (idle_cnt == 32'(HEARTBEAT_CYCLES - 1));

  always_comb begin
    state_next   = state;
    pop          = 1'b0;
    hb_load      = 1'b0;
    m_axis_tdata = '0;
    unique case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          state_next = ST_SYNC;
        end else if (hb_fire) begin
          hb_load    = 1'b1;
          state_next = ST_SYNC;
        end
      end
      ST_SYNC: begin
        m_axis_tdata = SYNC_BYTE;
        if (out_hs) state_next = ST_SEQ;
      end
      ST_SEQ: begin
        m_axis_tdata = seq;
        if (out_hs) state_next = ST_D3;
      end
      ST_D3: begin
        m_axis_tdata = hold[31:24];
        if (out_hs) state_next = ST_D2;
      end
      ST_D2: begin
        m_axis_tdata = hold[23:16];
        if (out_hs) state_next = ST_D1;
      end
      ST_D1: begin
        m_axis_tdata = hold[15:8];
        if (out_hs) state_next = ST_D0;
      end
      ST_D0: begin
        m_axis_tdata = hold[7:0];
        if (out_hs) state_next = ST_CHK;
      end
      ST_CHK: begin
        m_axis_tdata = chk;
        if (out_hs) begin
          // Back-to-back frames: pop the next word on the checksum handshake.
          if (!fifo_empty) begin
            pop        = 1'b1;
            state_next = ST_SYNC;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state        <= ST_IDLE;
      hold         <= '0;
      chk          <= '0;
      seq          <= '0;
      idle_cnt     <= '0;
      out_of_reset <= 1'b0;
    end else begin
      state        <= state_next;
      out_of_reset <= 1'b1;

      if (pop)          hold <= fifo_rdata;
      else if (hb_load) hold <= HEARTBEAT_WORD;

      // Counts only while idle with nothing to send; any frame start clears it.
      if (state == ST_IDLE && state_next == ST_IDLE && HEARTBEAT_CYCLES != 0)
        idle_cnt <= idle_cnt + 32'd1;
      else
        idle_cnt <= '0;

      if (out_hs) begin
        unique case (state)
          ST_SEQ:                      chk <= seq;
          ST_D3, ST_D2, ST_D1, ST_D0:  chk <= chk ^ m_axis_tdata;
          ST_CHK:                      seq <= seq + 8'd1;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spike_frame_serializer.sv
module tb_spike_frame_serializer;
  import spike_frame_serializer_pkg::*;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [31:0] s_tdata = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic [7:0]  m_tdata;
  logic        m_tvalid;
  logic        m_tready = 1'b0;
  logic [7:0]  seq_num;
  logic [2:0]  fifo_level;

  logic [31:0] hb_s_tdata = '0;
  logic        hb_s_tvalid = 1'b0;
  logic        hb_s_tready;
  logic [7:0]  hb_tdata;
  logic        hb_tvalid;
  logic        hb_m_tready = 1'b1;
  logic [7:0]  hb_seq;
  logic [2:0]  hb_level;

  always #5 aclk = ~aclk;

  spike_frame_serializer #(
    .FIFO_DEPTH       (4),
    .SYNC_BYTE        (8'hA5),
    .HEARTBEAT_CYCLES (0),
    .HEARTBEAT_WORD   (32'hFFFF_FFFF)
  ) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .seq_num       (seq_num),
    .fifo_level    (fifo_level)
  );

  spike_frame_serializer #(
    .FIFO_DEPTH       (4),
    .SYNC_BYTE        (8'hA5),
    .HEARTBEAT_CYCLES (20),
    .HEARTBEAT_WORD   (32'hFFFF_FFFF)
  ) dut_hb (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .s_axis_tdata  (hb_s_tdata),
    .s_axis_tvalid (hb_s_tvalid),
    .s_axis_tready (hb_s_tready),
    .m_axis_tdata  (hb_tdata),
    .m_axis_tvalid (hb_tvalid),
    .m_axis_tready (hb_m_tready),
    .seq_num       (hb_seq),
    .fifo_level    (hb_level)
  );

  typedef struct {
    logic [31:0] word;
    bit          bp;
    logic [7:0]  exp [7];
  } vec_t;

  vec_t        tbl [5];
  int          n_vec = 0;
  int          n_bad = 0;
  logic [31:0] tx_q [$];
  logic [7:0]  rx_q [$];
  int          rx_cyc [$];
  logic [7:0]  hb_q [$];
  int          hb_cyc [$];
  int          cyc = 0;
  int          hs_cyc = -1;
  int          first_v_cyc = -1;
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_data = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] frame_byte(input logic [7:0] s, input logic [31:0] w, input int i);
    case (i)
      0:       return 8'hA5;
      1:       return s;
      2:       return w[31:24];
      3:       return w[23:16];
      4:       return w[15:8];
      5:       return w[7:0];
      default: return s ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
    endcase
  endfunction

  // One clock: drive at negedge, evaluate handshakes, advance to next negedge.
  task automatic step();
    s_tvalid = (tx_q.size() != 0);
    s_tdata  = (tx_q.size() != 0) ? tx_q[0] : '0;
    #1;
    if (prev_stall) begin
      check("stall_valid", 32'(m_tvalid), 32'd1);
      check("stall_data", 32'(m_tdata), 32'(prev_data));
    end
    prev_stall = m_tvalid && !m_tready;
    prev_data  = m_tdata;
    if (m_tvalid && first_v_cyc < 0) first_v_cyc = cyc;
    if (s_tvalid && s_tready) begin
      if (hs_cyc < 0) hs_cyc = cyc;
      void'(tx_q.pop_front());
    end
    if (m_tvalid && m_tready) begin
      rx_q.push_back(m_tdata);
      rx_cyc.push_back(cyc);
    end
    if (hb_tvalid) begin
      hb_q.push_back(hb_tdata);
      hb_cyc.push_back(cyc);
    end
    @(negedge aclk);
    cyc++;
  endtask

  task automatic run_bytes(input int n, input bit bp, input int budget);
    int k = 0;
    while (rx_q.size() < n && k < budget) begin
      m_tready = bp ? ((k % 4 == 0) || (k % 4 == 3)) : 1'b1;
      step();
      k++;
    end
    m_tready = 1'b1;
    check("byte_count", 32'(rx_q.size()), 32'(n));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0].word = 32'h1234_5678; tbl[0].bp = 1'b0;
    tbl[0].exp  = '{8'hA5, 8'h00, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08};
    tbl[1].word = 32'h1234_5678; tbl[1].bp = 1'b1;
    tbl[1].exp  = '{8'hA5, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h09};
    tbl[2].word = 32'hDEAD_BEEF; tbl[2].bp = 1'b0;
    tbl[2].exp  = '{8'hA5, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h20};
    tbl[3].word = 32'hA5A5_A5A5; tbl[3].bp = 1'b1;
    tbl[3].exp  = '{8'hA5, 8'h03, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h03};
    tbl[4].word = 32'h0102_0408; tbl[4].bp = 1'b0;
    tbl[4].exp  = '{8'hA5, 8'h04, 8'h01, 8'h02, 8'h04, 8'h08, 8'h0B};

    // Reset state
    #2;
    check("rst_s_tready", 32'(s_tready), 32'd0);
    check("rst_m_tvalid", 32'(m_tvalid), 32'd0);
    check("rst_m_tdata", 32'(m_tdata), 32'd0);
    check("rst_seq", 32'(seq_num), 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    @(negedge aclk);
    aresetn = 1'b1;
    step();
    step();
    check("post_rst_s_tready", 32'(s_tready), 32'd1);

    // Table: single frames, some with 1-0-0-1 backpressure
    for (int v = 0; v < 5; v++) begin
      rx_q.delete();
      rx_cyc.delete();
      tx_q.push_back(tbl[v].word);
      run_bytes(FRAME_LEN, tbl[v].bp, 100);
      for (int b = 0; b < 7; b++)
        check($sformatf("vec%0d_byte%0d", v, b), 32'(rx_q[b]), 32'(tbl[v].exp[b]));
      check($sformatf("vec%0d_seq", v), 32'(seq_num), 32'(v + 1));
      if (v == 0) check("first_valid_latency", 32'(first_v_cyc - hs_cyc), 32'd2);
    end

    // Burst of 6 with output stalled, then drain back-to-back
    m_tready = 1'b0;
    for (int i = 0; i < 6; i++) tx_q.push_back(32'h1000_0000 * i + 32'h00C0_3C00 + i);
    for (int i = 0; i < 12; i++) step();
    check("burst_accepted", 32'(6 - tx_q.size()), 32'd5);
    check("burst_s_tready", 32'(s_tready), 32'd0);
    check("burst_level", 32'(fifo_level), 32'd4);
    check("burst_sync_held", 32'(m_tdata), 32'hA5);
    rx_q.delete();
    rx_cyc.delete();
    run_bytes(6 * FRAME_LEN, 1'b0, 200);
    for (int f = 0; f < 6; f++)
      for (int b = 0; b < 7; b++)
        check($sformatf("burst_f%0d_b%0d", f, b), 32'(rx_q[f * 7 + b]),
              32'(frame_byte(8'(5 + f), 32'h1000_0000 * f + 32'h00C0_3C00 + f, b)));
    check("burst_no_gaps", 32'(rx_cyc[41] - rx_cyc[0]), 32'd41);
    check("burst_seq", 32'(seq_num), 32'd11);

    // Heartbeats disabled: nothing over 1000 idle cycles
    rx_q.delete();
    rx_cyc.delete();
    m_tready = 1'b1;
    for (int i = 0; i < 1000; i++) step();
    check("hb0_silent", 32'(rx_q.size()), 32'd0);

    // Reset after the D2 byte
    rx_q.delete();
    rx_cyc.delete();
    tx_q.push_back(32'hCAFE_F00D);
    tx_q.push_back(32'h1111_2222);
    tx_q.push_back(32'h3333_4444);
    run_bytes(4, 1'b0, 100);
    check("mid_d2_byte", 32'(rx_q[3]), 32'hFE);
    check("mid_level", 32'(fifo_level), 32'd2);
    aresetn = 1'b0;
    tx_q.delete();
    s_tvalid = 1'b0;
    #1;
    check("mid_rst_tvalid", 32'(m_tvalid), 32'd0);
    check("mid_rst_level", 32'(fifo_level), 32'd0);
    check("mid_rst_seq", 32'(seq_num), 32'd0);
    @(negedge aclk);
    aresetn = 1'b1;
    hb_q.delete();
    hb_cyc.delete();
    rx_q.delete();
    rx_cyc.delete();
    step();
    check("after_rst_level", 32'(fifo_level), 32'd0);
    tx_q.push_back(32'h0F0F_0F0F);
    run_bytes(FRAME_LEN, 1'b0, 100);
    begin
      logic [7:0] ex [7];
      ex = '{8'hA5, 8'h00, 8'h0F, 8'h0F, 8'h0F, 8'h0F, 8'h00};
      for (int b = 0; b < 7; b++)
        check($sformatf("after_rst_b%0d", b), 32'(rx_q[b]), 32'(ex[b]));
    end

    // Heartbeat instance: two frames, 20 idle cycles between them
    begin
      int k = 0;
      logic [7:0] hx [14];
      hx = '{8'hA5, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00,
             8'hA5, 8'h01, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h01};
      while (hb_q.size() < 14 && k < 200) begin
        step();
        k++;
      end
      check("hb_count", 32'(hb_q.size()), 32'd14);
      for (int b = 0; b < 14; b++)
        check($sformatf("hb_b%0d", b), 32'(hb_q[b]), 32'(hx[b]));
      check("hb_gap", 32'(hb_cyc[7] - hb_cyc[6]), 32'd21);
      check("hb_seq", 32'(hb_seq), 32'd2);
      check("hb_level", 32'(hb_level), 32'd0);
      check("hb_s_tready", 32'(hb_s_tready), 32'd1);
    end

    // Sequence wrap: 257 frames starting at seq 1
    rx_q.delete();
    rx_cyc.delete();
    for (int i = 0; i < 257; i++)
      tx_q.push_back({8'(i) ^ 8'h5A, 8'(i), 8'h3C, ~8'(i)});
    run_bytes(257 * FRAME_LEN, 1'b0, 257 * 7 + 50);
    for (int f = 0; f < 257; f++)
      for (int b = 0; b < 7; b++)
        check($sformatf("wrap_f%0d_b%0d", f, b), 32'(rx_q[f * 7 + b]),
              32'(frame_byte(8'(1 + f), {8'(f) ^ 8'h5A, 8'(f), 8'h3C, ~8'(f)}, b)));
    check("wrap_seq", 32'(seq_num), 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
